// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo-core definitions: default bus widths, the CDB payload
// layout and the opcode encodings the reservation-station selector decodes.
package tomasulo_pkg;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 4;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_payload_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;

endpackage

// File: rtl/cdb_chan_fifo.sv
// Per-channel result FIFO feeding the CDB arbiter. Strictly in order; a push and
// a pop in the same cycle both take effect and the pop returns the old head.
module cdb_chan_fifo #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [TAG_W-1:0]          tag_i,
    input  logic [DATA_W-1:0]         data_i,
    output logic [TAG_W+DATA_W-1:0]   head_o,
    output logic                      full_o,
    output logic                      empty_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = TAG_W + DATA_W;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               doPush, doPop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign doPush  = push_i && !full_o && !reset;
    assign doPop   = pop_i && !empty_o;
    assign head_o  = mem_q[rdPtr_q];

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        if (doPush && !doPop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (!doPush && doPop) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= {tag_i, data_i};
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: buffers completed results per functional-unit channel
// and broadcasts one of them per cycle on a registered CDB.
module cdb_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = tomasulo_pkg::DATA_W,
    parameter int TAG_W   = tomasulo_pkg::TAG_W,
    parameter int DEPTH   = 4,
    parameter int RR_MODE = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH*TAG_W-1:0]    in_tag,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    output logic [NUM_CH-1:0]          in_ready,
    output logic                       cdb_valid,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [DATA_W-1:0]          cdb_data,
    output logic [NUM_CH-1:0]          cdb_grant,
    output logic [NUM_CH-1:0]          pending
);

    localparam int CH_W    = $clog2(NUM_CH);
    localparam int ENTRY_W = TAG_W + DATA_W;

    logic [NUM_CH-1:0]  full, empty, push, pop, candidates;
    logic [ENTRY_W-1:0] head [NUM_CH];

    logic [CH_W-1:0]    rrPtr_q, rrPtr_d;
    logic [CH_W-1:0]    grantIdx, scanIdx;
    logic [CH_W:0]      scanSum;
    logic               found;

    logic               cdbValid_q, cdbValid_d;
    logic [TAG_W-1:0]   cdbTag_q, cdbTag_d;
    logic [DATA_W-1:0]  cdbData_q, cdbData_d;
    logic [NUM_CH-1:0]  cdbGrant_q, cdbGrant_d;

    // Ready is purely from fullness: a same-cycle pop does not free a slot early.
    assign in_ready   = ~full & {NUM_CH{~reset}};
    assign pending    = ~empty & {NUM_CH{~reset}};
    assign candidates = ~empty;
    assign push       = in_valid & in_ready;
    assign pop        = (found && !reset) ? (NUM_CH'(1) << grantIdx) : '0;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_fifo
        cdb_chan_fifo #(
            .DEPTH  (DEPTH),
            .TAG_W  (TAG_W),
            .DATA_W (DATA_W)
        ) u_fifo (
            .clock   (clock),
            .reset   (reset),
            .push_i  (push[ch]),
            .pop_i   (pop[ch]),
            .tag_i   (in_tag[ch*TAG_W +: TAG_W]),
            .data_i  (in_data[ch*DATA_W +: DATA_W]),
            .head_o  (head[ch]),
            .full_o  (full[ch]),
            .empty_o (empty[ch])
        );
    end

    // Scan starts at rrPtr_q (round-robin) or at channel 0 (fixed priority).
    always_comb begin
        found    = 1'b0;
        grantIdx = '0;
        scanSum  = '0;
        scanIdx  = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            if (RR_MODE != 0) begin
                scanSum = {1'b0, rrPtr_q} + (CH_W+1)'(off);
                if (scanSum >= (CH_W+1)'(NUM_CH)) begin
                    scanSum = scanSum - (CH_W+1)'(NUM_CH);
                end
                scanIdx = scanSum[CH_W-1:0];
            end else begin
                scanIdx = CH_W'(off);
            end
            if (!found && candidates[scanIdx]) begin
                found    = 1'b1;
                grantIdx = scanIdx;
            end
        end
    end

    // Tag/data hold their last value across idle cycles; valid/grant drop.
    always_comb begin
        cdbValid_d = 1'b0;
        cdbGrant_d = '0;
        cdbTag_d   = cdbTag_q;
        cdbData_d  = cdbData_q;
        rrPtr_d    = rrPtr_q;
        if (found) begin
            cdbValid_d = 1'b1;
            cdbTag_d   = head[grantIdx][ENTRY_W-1 -: TAG_W];
            cdbData_d  = head[grantIdx][DATA_W-1:0];
            cdbGrant_d = NUM_CH'(1) << grantIdx;
            if (RR_MODE != 0) begin
                rrPtr_d = (grantIdx == CH_W'(NUM_CH - 1)) ? '0 : grantIdx + CH_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cdbValid_q <= 1'b0;
            cdbTag_q   <= '0;
            cdbData_q  <= '0;
            cdbGrant_q <= '0;
            rrPtr_q    <= '0;
        end else begin
            cdbValid_q <= cdbValid_d;
            cdbTag_q   <= cdbTag_d;
            cdbData_q  <= cdbData_d;
            cdbGrant_q <= cdbGrant_d;
            rrPtr_q    <= rrPtr_d;
        end
    end

    assign cdb_valid = cdbValid_q;
    assign cdb_tag   = cdbTag_q;
    assign cdb_data  = cdbData_q;
    assign cdb_grant = cdbGrant_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a round-robin instance (dut 0) and a fixed-priority
// instance (dut 1) are both checked every cycle against a queue-based model.
module tb_cdb_arbiter;

    localparam int NCH = 2;
    localparam int TW  = 4;
    localparam int DW  = 4;
    localparam int DEP = 4;

    logic clock;
    logic reset;

    logic [NCH-1:0]    inValid  [2];
    logic [NCH*TW-1:0] inTag    [2];
    logic [NCH*DW-1:0] inData   [2];
    logic [NCH-1:0]    inReady  [2];
    logic              cdbValid [2];
    logic [TW-1:0]     cdbTag   [2];
    logic [DW-1:0]     cdbData  [2];
    logic [NCH-1:0]    cdbGrant [2];
    logic [NCH-1:0]    pending  [2];

    // Model state: producer queues, per-channel buffers, expected CDB registers.
    // Queue index is dut*NCH + channel; items are {tag, data}.
    logic [7:0] srcQ  [2*NCH][$];
    logic [7:0] fifoQ [2*NCH][$];
    logic [9:0] bcastLog [2][$];
    int         rrPtr    [2];
    logic       expValid [2];
    logic [3:0] expTag   [2];
    logic [3:0] expData  [2];
    logic [1:0] expGrant [2];

    int compared   = 0;
    int mismatched = 0;

    cdb_arbiter #(
        .NUM_CH (NCH), .DATA_W (DW), .TAG_W (TW), .DEPTH (DEP), .RR_MODE (1)
    ) dutRr (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (inValid[0]),
        .in_tag    (inTag[0]),
        .in_data   (inData[0]),
        .in_ready  (inReady[0]),
        .cdb_valid (cdbValid[0]),
        .cdb_tag   (cdbTag[0]),
        .cdb_data  (cdbData[0]),
        .cdb_grant (cdbGrant[0]),
        .pending   (pending[0])
    );

    cdb_arbiter #(
        .NUM_CH (NCH), .DATA_W (DW), .TAG_W (TW), .DEPTH (DEP), .RR_MODE (0)
    ) dutFp (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (inValid[1]),
        .in_tag    (inTag[1]),
        .in_data   (inData[1]),
        .in_ready  (inReady[1]),
        .cdb_valid (cdbValid[1]),
        .cdb_tag   (cdbTag[1]),
        .cdb_data  (cdbData[1]),
        .cdb_grant (cdbGrant[1]),
        .pending   (pending[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Producers present the head of their queue and hold it until accepted.
    task automatic driveInputs();
        logic [7:0] item;
        for (int i = 0; i < 2; i++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (srcQ[i*NCH+ch].size() > 0) begin
                    item = srcQ[i*NCH+ch][0];
                    inValid[i][ch] = 1'b1;
                    inTag[i][ch*TW +: TW] = item[7:4];
                    inData[i][ch*DW +: DW] = item[3:0];
                end else begin
                    inValid[i][ch] = 1'b0;
                    inTag[i][ch*TW +: TW] = '0;
                    inData[i][ch*DW +: DW] = '0;
                end
            end
        end
    endtask

    // One clock cycle: check handshake outputs before the edge, advance the
    // model with the pre-edge state, then check the CDB registers after it.
    task automatic tick();
        logic       acc [2*NCH];
        logic       expReady, expPend;
        logic [7:0] item;
        int         win, c, k;
        driveInputs();
        #1;
        for (int i = 0; i < 2; i++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                k = i*NCH + ch;
                expReady = !reset && (fifoQ[k].size() < DEP);
                expPend  = !reset && (fifoQ[k].size() > 0);
                compared++;
                if (inReady[i][ch] !== expReady) begin
                    mismatched++;
                    $display("[TB] FAIL in_ready dut%0d ch%0d: got %b expected %b", i, ch, inReady[i][ch], expReady);
                end
                compared++;
                if (pending[i][ch] !== expPend) begin
                    mismatched++;
                    $display("[TB] FAIL pending dut%0d ch%0d: got %b expected %b", i, ch, pending[i][ch], expPend);
                end
                acc[k] = expReady && (srcQ[k].size() > 0);
            end
        end
        @(posedge clock);
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                for (int ch = 0; ch < NCH; ch++) fifoQ[i*NCH+ch].delete();
                rrPtr[i]    = 0;
                expValid[i] = 1'b0;
                expTag[i]   = '0;
                expData[i]  = '0;
                expGrant[i] = '0;
            end else begin
                win = -1;
                for (int off = 0; off < NCH; off++) begin
                    c = (i == 0) ? (rrPtr[i] + off) % NCH : off;
                    if (win < 0 && fifoQ[i*NCH+c].size() > 0) win = c;
                end
                if (win >= 0) begin
                    item        = fifoQ[i*NCH+win].pop_front();
                    expValid[i] = 1'b1;
                    expTag[i]   = item[7:4];
                    expData[i]  = item[3:0];
                    expGrant[i] = 2'(1 << win);
                    if (i == 0) rrPtr[i] = (win + 1) % NCH;
                end else begin
                    expValid[i] = 1'b0;
                    expGrant[i] = '0;
                end
                for (int ch = 0; ch < NCH; ch++) begin
                    if (acc[i*NCH+ch]) fifoQ[i*NCH+ch].push_back(srcQ[i*NCH+ch].pop_front());
                end
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            compared++;
            if (cdbValid[i] !== expValid[i]) begin
                mismatched++;
                $display("[TB] FAIL cdb_valid dut%0d: got %b expected %b", i, cdbValid[i], expValid[i]);
            end
            compared++;
            if (cdbGrant[i] !== expGrant[i]) begin
                mismatched++;
                $display("[TB] FAIL cdb_grant dut%0d: got %b expected %b", i, cdbGrant[i], expGrant[i]);
            end
            compared++;
            if (cdbTag[i] !== expTag[i]) begin
                mismatched++;
                $display("[TB] FAIL cdb_tag dut%0d: got %h expected %h", i, cdbTag[i], expTag[i]);
            end
            compared++;
            if (cdbData[i] !== expData[i]) begin
                mismatched++;
                $display("[TB] FAIL cdb_data dut%0d: got %h expected %h", i, cdbData[i], expData[i]);
            end
            if (cdbValid[i] === 1'b1) bcastLog[i].push_back({cdbGrant[i], cdbTag[i], cdbData[i]});
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        for (int k = 0; k < 2*NCH; k++) srcQ[k].push_back(8'($urandom));
        reset = 1'b1;
        tick();
        tick();
        compared++;
        if (inReady[0] !== 2'b00 || inReady[1] !== 2'b00 || cdbValid[0] !== 1'b0 || cdbTag[0] !== 4'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got ready %b/%b valid %b tag %h expected all 0", inReady[0], inReady[1], cdbValid[0], cdbTag[0]);
        end
        for (int k = 0; k < 2*NCH; k++) srcQ[k].delete();
        reset = 1'b0;
        tick();
        tick();
        compared++;
        if (bcastLog[0].size() != 0 || bcastLog[1].size() != 0) begin
            mismatched++;
            $display("[TB] FAIL reset_no_bcast: got %0d/%0d broadcasts expected 0", bcastLog[0].size(), bcastLog[1].size());
        end
    endtask

    task automatic test_single();
        $display("[TB] test_single");
        srcQ[0].push_back(8'h39);
        tick();
        compared++;
        if (cdbValid[0] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_early: got valid %b expected 0", cdbValid[0]);
        end
        tick();
        compared++;
        if (cdbValid[0] !== 1'b1 || cdbTag[0] !== 4'h3 || cdbData[0] !== 4'h9 || cdbGrant[0] !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL single_bcast: got v%b t%h d%h g%b expected v1 t3 d9 g01", cdbValid[0], cdbTag[0], cdbData[0], cdbGrant[0]);
        end
        tick();
        compared++;
        if (cdbValid[0] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_after: got valid %b expected 0", cdbValid[0]);
        end
    endtask

    task automatic test_simultaneous();
        int n;
        $display("[TB] test_simultaneous");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n = bcastLog[0].size();
        srcQ[0].push_back(8'h15);
        srcQ[1].push_back(8'h27);
        repeat (3) tick();
        compared++;
        if (bcastLog[0].size() != n + 2 || bcastLog[0][n][7:4] != 4'h1 || bcastLog[0][n+1][7:4] != 4'h2) begin
            mismatched++;
            $display("[TB] FAIL rr_order_first: got %0d bcasts first tag %h expected tags 1 then 2", bcastLog[0].size() - n, bcastLog[0][n][7:4]);
        end
        // A lone ch0 grant leaves the pointer at ch1, so the next pair flips.
        srcQ[0].push_back(8'h44);
        repeat (2) tick();
        n = bcastLog[0].size();
        srcQ[0].push_back(8'h15);
        srcQ[1].push_back(8'h27);
        repeat (3) tick();
        compared++;
        if (bcastLog[0].size() != n + 2 || bcastLog[0][n][7:4] != 4'h2 || bcastLog[0][n+1][7:4] != 4'h1) begin
            mismatched++;
            $display("[TB] FAIL rr_order_second: got %0d bcasts first tag %h expected tags 2 then 1", bcastLog[0].size() - n, bcastLog[0][n][7:4]);
        end
    endtask

    task automatic test_fixed_priority();
        int n, seen0, seen1;
        logic [9:0] e;
        $display("[TB] test_fixed_priority");
        n = bcastLog[1].size();
        for (int j = 0; j < 10; j++) srcQ[3].push_back({4'hA, 4'(j)});
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (cyc % 4 == 1 && cyc < 16) srcQ[2].push_back({4'(cyc / 4), 4'hC});
            tick();
        end
        seen0 = 0;
        seen1 = 0;
        for (int j = n; j < bcastLog[1].size(); j++) begin
            e = bcastLog[1][j];
            if (e[9:8] == 2'b10) begin
                compared++;
                if (e[3:0] != 4'(seen1)) begin
                    mismatched++;
                    $display("[TB] FAIL fp_ch1_order: got data %h expected %h", e[3:0], 4'(seen1));
                end
                seen1++;
            end else begin
                seen0++;
            end
        end
        compared++;
        if (seen1 != 10 || seen0 != 4) begin
            mismatched++;
            $display("[TB] FAIL fp_counts: got ch0 %0d ch1 %0d expected 4 and 10", seen0, seen1);
        end
    endtask

    task automatic test_backpressure();
        int n, seen0, seen1;
        logic [9:0] e;
        $display("[TB] test_backpressure");
        n = bcastLog[1].size();
        for (int j = 0; j < 12; j++) srcQ[2].push_back({4'(j), 4'h5});
        for (int j = 0; j < 5; j++) srcQ[3].push_back({4'hB, 4'(j)});
        repeat (6) tick();
        compared++;
        if (inReady[1][1] !== 1'b0 || pending[1][1] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL bp_full: got ready %b pending %b expected 0 and 1", inReady[1][1], pending[1][1]);
        end
        repeat (24) tick();
        seen0 = 0;
        seen1 = 0;
        for (int j = n; j < bcastLog[1].size(); j++) begin
            e = bcastLog[1][j];
            if (e[9:8] == 2'b10) begin
                compared++;
                if (e[3:0] != 4'(seen1)) begin
                    mismatched++;
                    $display("[TB] FAIL bp_ch1_order: got data %h expected %h", e[3:0], 4'(seen1));
                end
                seen1++;
            end else begin
                seen0++;
            end
        end
        compared++;
        if (seen1 != 5 || seen0 != 12) begin
            mismatched++;
            $display("[TB] FAIL bp_counts: got ch0 %0d ch1 %0d expected 12 and 5", seen0, seen1);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        $display("[TB] test_reset_mid");
        for (int j = 0; j < 3; j++) begin
            srcQ[0].push_back({4'(j), 4'h1});
            srcQ[1].push_back({4'(j + 8), 4'h2});
        end
        tick();
        tick();
        n = bcastLog[0].size();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        srcQ[0].delete();
        srcQ[1].delete();
        repeat (4) tick();
        compared++;
        if (bcastLog[0].size() != n) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_bcast: got %0d broadcasts after reset expected 0", bcastLog[0].size() - n);
        end
        compared++;
        if (pending[0] !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_pending: got %b expected 00", pending[0]);
        end
    endtask

    task automatic test_random();
        $display("[TB] test_random");
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < 2*NCH; k++) begin
                if (srcQ[k].size() < 2 && $urandom_range(0, 99) < 40) srcQ[k].push_back(8'($urandom));
            end
            reset = ($urandom_range(0, 99) < 2);
            tick();
        end
        reset = 1'b0;
        repeat (20) tick();
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            inValid[i]  = '0;
            inTag[i]    = '0;
            inData[i]   = '0;
            rrPtr[i]    = 0;
            expValid[i] = 1'b0;
            expTag[i]   = '0;
            expData[i]  = '0;
            expGrant[i] = '0;
        end
        test_reset();
        test_single();
        test_simultaneous();
        test_fixed_priority();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
